// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential divider.
//   state_t     : controller states (IDLE, CALC, DONE)
//   cnt_width() : width of the CALC step counter, clog2(N/K+1)
//   twos_neg()  : two's-complement negation on a MAX_W-bit container
//   magnitude() : conditional negation, used for operand magnitudes and
//                 for sign-correcting results
// Callers zero-extend into MAX_W bits and size-cast the result back to N.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    function automatic int cnt_width(input int n, input int k);
        return $clog2(n / k + 1);
    endfunction

    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] x,
                                                   input logic            neg);
        return neg ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control FSM and seq_divider.
//   i_start, i_signed, i_dividend, i_divisor : operation request
//   o_busy, o_finished                       : handshake status
//   o_quotient, o_remainder                  : results, valid while o_finished
//   o_div_zero, o_overflow                   : flags, valid while o_finished
// master: requester side.  slave: divider side.
interface seq_divider_if #(
    parameter int N = 8
);
    logic         i_start;
    logic         i_signed;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         o_busy;
    logic         o_finished;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;
    logic         o_div_zero;
    logic         o_overflow;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor,
        input  o_busy, o_finished, o_quotient, o_remainder, o_div_zero, o_overflow
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor,
        output o_busy, o_finished, o_quotient, o_remainder, o_div_zero, o_overflow
    );
endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder (N+1 bits, always < divisor on entry)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor magnitude
//   rem_out : updated partial remainder
//   q_bit   : quotient bit resolved by this step
module divider_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);
    // One spare bit so the shift can never wrap before the compare.
    logic [N+1:0] shifted;
    logic [N+1:0] dext;

    always_comb begin
        shifted = {rem_in, bit_in};
        dext    = {2'b00, divisor};
        q_bit   = (shifted >= dext);
        // Result is < divisor, so it always fits back in N+1 bits.
        rem_out = (N+1)'(q_bit ? (shifted - dext) : shifted);
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, K quotient bits per clock.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset, aborts any operation
//   bus     : seq_divider_if.slave request/result bundle
// Parameters: N operand width (>=2), K bits per cycle (must divide N).
// Optional build macro DIVIDER_EARLY_EXIT_EN: finish in one cycle when
// |dividend| < |divisor|; otherwise such operands take the full N/K cycles
// and give the same result.
// Division-by-zero and signed most-negative/-1 always finish in one cycle.
module seq_divider
    import divider_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    seq_divider_if.slave  bus
);
    localparam int STEPS = N / K;
    localparam int CW    = cnt_width(N, K);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (N < 2 || K < 1 || (N % K) != 0 || N > MAX_W) begin : g_param_err
        $error("seq_divider: need N>=2, N<=64, K>=1 and K dividing N");
    end

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [N:0]     rem_q;      // partial remainder
    logic [N-1:0]   dvd_q;      // dividend bits out at MSB, quotient bits in at LSB
    logic [N-1:0]   dvs_q;      // divisor magnitude
    logic           q_neg;
    logic           r_neg;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    // ---- accept-time decode ----
    logic         accept;
    logic         a_neg, b_neg;
    logic [N-1:0] mag_a, mag_b;
    logic         is_zero, is_ovf, is_early, shortcut;

    assign accept  = bus.i_start && (state != CALC);
    assign a_neg   = bus.i_signed & bus.i_dividend[N-1];
    assign b_neg   = bus.i_signed & bus.i_divisor[N-1];
    assign mag_a   = N'(magnitude(MAX_W'(bus.i_dividend), a_neg));
    assign mag_b   = N'(magnitude(MAX_W'(bus.i_divisor),  b_neg));
    assign is_zero = (bus.i_divisor == '0);
    assign is_ovf  = bus.i_signed && (bus.i_dividend == {1'b1, {(N-1){1'b0}}})
                     && (bus.i_divisor == '1);
`ifdef DIVIDER_EARLY_EXIT_EN
    // Magnitude compare: quotient is 0 and remainder is the dividend itself.
    assign is_early = !is_zero && (mag_a < mag_b);
`else
    assign is_early = 1'b0;
`endif
    assign shortcut = is_zero | is_ovf | is_early;

    // ---- K-step restoring chain ----
    logic [K:0][N:0] rem_chain;
    logic [K-1:0]    q_bits;
    logic [N-1:0]    dvd_next;
    logic [N-1:0]    q_fin, r_fin;

    assign rem_chain[0] = rem_q;

    for (genvar j = 0; j < K; j++) begin : g_step
        divider_step #(.N(N)) u_step (
            .rem_in  (rem_chain[j]),
            .bit_in  (dvd_q[N-1-j]),
            .divisor (dvs_q),
            .rem_out (rem_chain[j+1]),
            .q_bit   (q_bits[K-1-j])
        );
    end

    assign dvd_next = (dvd_q << K) | N'(q_bits);
    assign q_fin    = N'(magnitude(MAX_W'(dvd_next), q_neg));
    assign r_fin    = N'(magnitude(MAX_W'(N'(rem_chain[K])), r_neg));

    // ---- controller ----
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: if (accept) state_n = shortcut ? DONE : CALC;
            CALC:       if (cnt == LAST) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    // ---- datapath / result registers ----
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem_q    <= '0;
            dvd_q    <= mag_a;
            dvs_q    <= mag_b;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= is_zero;
            overflow <= is_ovf;
            if (is_zero) begin
                quotient  <= '1;
                remainder <= bus.i_dividend;
            end else if (is_ovf) begin
                quotient  <= {1'b1, {(N-1){1'b0}}};
                remainder <= '0;
            end else if (is_early) begin
                quotient  <= '0;
                remainder <= bus.i_dividend;
            end else begin
                quotient  <= '0;
                remainder <= '0;
            end
        end else if (state == CALC) begin
            cnt   <= cnt + CW'(1);
            rem_q <= rem_chain[K];
            dvd_q <= dvd_next;
            if (cnt == LAST) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end
        end
    end

    assign bus.o_busy      = (state == CALC);
    assign bus.o_finished  = (state == DONE);
    assign bus.o_quotient  = quotient;
    assign bus.o_remainder = remainder;
    assign bus.o_div_zero  = div_zero;
    assign bus.o_overflow  = overflow;
endmodule
